// File: rtl/serial_borrow_subtractor.sv
// rtl/serial_borrow_subtractor.sv - bit-serial A - B - Bin subtractor, LSB first, start/done handshake; optional SUB_OVF_EN adds signed overflow output
module serial_borrow_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             diff_bit;
  logic             borrow_next;
  logic             last_bit;
  logic [WIDTH-1:0] final_res;

`ifdef SUB_OVF_EN
  // Operand sign bits are kept because the shift registers lose them during RUN.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    diff_bit    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    borrow_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    last_bit    = (cnt_q == CW'(WIDTH - 1));
    final_res   = {diff_bit, res_q[WIDTH-1:1]};
  end

  // Next-state and datapath control; DONE accepts start exactly like IDLE.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    d_d     = d_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d  = final_res;
        br_d   = borrow_next;
        cnt_d  = cnt_q + 1'b1;
        if (last_bit) begin
          state_d = S_DONE;
          d_d     = final_res;
          bout_d  = borrow_next;
`ifdef SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
`endif
        end
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = A;
          b_sh_d  = B;
          res_d   = '0;
          br_d    = Bin;
          cnt_d   = '0;
`ifdef SUB_OVF_EN
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
`ifdef SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Outputs decode directly from registered state, so done is a clean one-cycle pulse.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    D    = d_q;
    Bout = bout_q;
`ifdef SUB_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule
